// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   hz_state_e : controller FSM state encoding (visible on hz_state)
//   hz_event_e : the single highest-priority event decoded each cycle
//   CNT_W_DEFAULT : default width of the performance counters
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } hz_state_e;

  typedef enum logic [2:0] {
    EV_NONE      = 3'd0,
    EV_IMEM_WAIT = 3'd1,
    EV_LOAD_USE  = 3'd2,
    EV_REDIRECT  = 3'd3,
    EV_MEM_BUSY  = 3'd4
  } hz_event_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_cnt.sv
// hazard_cnt: saturating up-counter with synchronous clear.
//   clk   : clock
//   rst   : synchronous active-high reset, count -> 0
//   clr   : synchronous clear, wins over inc
//   inc   : count up by one, holding at all-ones
//   count : current value
module hazard_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for a 5-stage in-order pipeline.
// Decodes the highest-priority hazard each cycle and drives pipeline-register
// write enables and bubble-insert controls combinationally, so a hazard acts
// in the cycle it is detected.
//   clk_HZD, rst_HZD           : clock, synchronous active-high reset
//   ID_* / EX_*                : operand/destination info of the ID and EX instrs
//   EX_redirect                : taken control transfer resolved in EX
//   imem_ready, dmem_busy      : memory handshakes
//   cnt_clr                    : clears both performance counters
//   en_*                       : pipeline-register write enables
//   NOP_IFID, NOP_IDEX         : bubble inserts (qualified by matching enable)
//   hz_state                   : current FSM state
//   stall_count, flush_count   : saturating performance counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter bit          X0_FREE = 1'b1
) (
  input  logic             clk_HZD,
  input  logic             rst_HZD,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic             ID_valid,
  input  logic [4:0]       EX_rd,
  input  logic             EX_MemRead,
  input  logic             EX_valid,
  input  logic             EX_redirect,
  input  logic             imem_ready,
  input  logic             dmem_busy,
  input  logic             cnt_clr,
  output logic             en_PC,
  output logic             en_IFID,
  output logic             en_IDEX,
  output logic             en_EXMEM,
  output logic             en_MEMWB,
  output logic             NOP_IFID,
  output logic             NOP_IDEX,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  hz_state_e state_q;
  hz_state_e state_d;
  hz_event_e ev;

  logic rs_match;
  logic rd_ok;
  logic load_use;
  logic lu_mask;

  assign rs_match = (ID_use_rs1 && (ID_rs1 == EX_rd)) ||
                    (ID_use_rs2 && (ID_rs2 == EX_rd));
  assign rd_ok    = !X0_FREE || (EX_rd != 5'd0);
  assign load_use = EX_valid && EX_MemRead && ID_valid && rs_match && rd_ok;

  // The cycle after a load stall or a flush, the ID instruction is either the
  // one just resolved or a bubble, so re-detecting would double-stall.
  assign lu_mask  = (state_q == LOAD_STALL) || (state_q == FLUSH);

  always_comb begin
    ev = EV_NONE;
    if (dmem_busy) begin
      ev = EV_MEM_BUSY;
    end else if (EX_redirect) begin
      ev = EV_REDIRECT;
    end else if (load_use && !lu_mask) begin
      ev = EV_LOAD_USE;
    end else if (!imem_ready) begin
      ev = EV_IMEM_WAIT;
    end
  end

  // State register
  always_ff @(posedge clk_HZD) begin
    if (rst_HZD) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (ev)
      EV_MEM_BUSY:  state_d = MEM_WAIT;
      EV_REDIRECT:  state_d = FLUSH;
      EV_LOAD_USE:  state_d = LOAD_STALL;
      // Fetch wait holds the state, except MEM_WAIT which is resolved
      // as if from RUN once the data access completes.
      EV_IMEM_WAIT: state_d = (state_q == MEM_WAIT) ? RUN : state_q;
      default:      state_d = RUN;
    endcase
  end

  // Outputs; reset forces the pass-through pattern so every pipeline
  // register sees its own reset and no bubble lingers.
  always_comb begin
    en_PC    = 1'b1;
    en_IFID  = 1'b1;
    en_IDEX  = 1'b1;
    en_EXMEM = 1'b1;
    en_MEMWB = 1'b1;
    NOP_IFID = 1'b0;
    NOP_IDEX = 1'b0;
    if (!rst_HZD) begin
      unique case (ev)
        EV_MEM_BUSY: begin
          en_PC    = 1'b0;
          en_IFID  = 1'b0;
          en_IDEX  = 1'b0;
          en_EXMEM = 1'b0;
          en_MEMWB = 1'b0;
        end
        EV_REDIRECT: begin
          NOP_IFID = 1'b1;
          NOP_IDEX = 1'b1;
        end
        EV_LOAD_USE: begin
          en_PC    = 1'b0;
          en_IFID  = 1'b0;
          NOP_IDEX = 1'b1;
        end
        EV_IMEM_WAIT: begin
          en_PC    = 1'b0;
          NOP_IFID = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hz_state = state_q;

  hazard_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_HZD),
    .rst   (rst_HZD),
    .clr   (cnt_clr),
    .inc   (!en_PC),
    .count (stall_count)
  );

  hazard_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk_HZD),
    .rst   (rst_HZD),
    .clr   (cnt_clr),
    .inc   ((ev == EV_REDIRECT) && !rst_HZD),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expectations.
// The control bundle is compared as
// {en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB, NOP_IFID, NOP_IDEX}.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CW = 4;

  localparam logic [6:0] C_RUN   = 7'b11111_00;
  localparam logic [6:0] C_LU    = 7'b00111_01;
  localparam logic [6:0] C_FLUSH = 7'b11111_11;
  localparam logic [6:0] C_MEM   = 7'b00000_00;
  localparam logic [6:0] C_IMEM  = 7'b01111_10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_valid = 1'b0;
  logic          ex_memread = 1'b0, ex_valid = 1'b0, ex_redirect = 1'b0;
  logic          imem_ready = 1'b1, dmem_busy = 1'b0, cnt_clr = 1'b0;
  logic          en_pc, en_ifid, en_idex, en_exmem, en_memwb, nop_ifid, nop_idex;
  logic [1:0]    hz_state;
  logic [CW-1:0] stall_count, flush_count;
  logic [6:0]    ctl;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  assign ctl = {en_pc, en_ifid, en_idex, en_exmem, en_memwb, nop_ifid, nop_idex};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CW), .X0_FREE(1'b1)) dut (
    .clk_HZD     (clk),
    .rst_HZD     (rst),
    .ID_rs1      (id_rs1),
    .ID_rs2      (id_rs2),
    .ID_use_rs1  (id_use_rs1),
    .ID_use_rs2  (id_use_rs2),
    .ID_valid    (id_valid),
    .EX_rd       (ex_rd),
    .EX_MemRead  (ex_memread),
    .EX_valid    (ex_valid),
    .EX_redirect (ex_redirect),
    .imem_ready  (imem_ready),
    .dmem_busy   (dmem_busy),
    .cnt_clr     (cnt_clr),
    .en_PC       (en_pc),
    .en_IFID     (en_ifid),
    .en_IDEX     (en_idex),
    .en_EXMEM    (en_exmem),
    .en_MEMWB    (en_memwb),
    .NOP_IFID    (nop_ifid),
    .NOP_IDEX    (nop_idex),
    .hz_state    (hz_state),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    ex_valid = 1'b0; ex_memread = 1'b0; ex_redirect = 1'b0;
    imem_ready = 1'b1; dmem_busy = 1'b0; cnt_clr = 1'b0;
  endtask

  // Load into x<rd> in EX, ID reads x<rs> on rs1
  task automatic load_use_rs1(input logic [4:0] rd, input logic [4:0] rs);
    ex_valid = 1'b1; ex_memread = 1'b1; ex_rd = rd;
    id_valid = 1'b1; id_use_rs1 = 1'b1; id_rs1 = rs;
  endtask

  task automatic settle_check(input string tag, input logic [6:0] exp);
    #1;
    check(tag, 32'(ctl), 32'(exp));
  endtask

  task automatic state_check(input string tag, input logic [1:0] st,
                             input logic [CW-1:0] sc, input logic [CW-1:0] fc);
    check({tag, "_state"}, 32'(hz_state), 32'(st));
    check({tag, "_stall"}, 32'(stall_count), 32'(sc));
    check({tag, "_flush"}, 32'(flush_count), 32'(fc));
  endtask

  initial begin
    // Reset overrides a concurrent dmem_busy and load-use
    rst = 1'b1; dmem_busy = 1'b1; load_use_rs1(5'd5, 5'd5);
    settle_check("rst_ctl", C_RUN);
    tick(); tick();
    state_check("rst", 2'd0, 4'd0, 4'd0);
    rst = 1'b0; idle();
    settle_check("idle_ctl", C_RUN);

    // Load x5 / use x5: one stall cycle, masked on the following cycle
    load_use_rs1(5'd5, 5'd5);
    settle_check("lu_ctl", C_LU);
    tick();
    state_check("lu", 2'd1, 4'd1, 4'd0);
    settle_check("lu_masked_ctl", C_RUN);
    tick();
    state_check("lu_exit", 2'd0, 4'd1, 4'd0);

    // x0 destination never stalls
    load_use_rs1(5'd0, 5'd0);
    settle_check("x0_ctl", C_RUN);
    tick();
    check("x0_state", 32'(hz_state), 32'd0);

    // rs2 path, rs1 not in use
    idle();
    ex_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd7;
    id_valid = 1'b1; id_use_rs2 = 1'b1; id_rs2 = 5'd7; id_rs1 = 5'd7;
    settle_check("rs2_ctl", C_LU);
    tick();
    check("rs2_state", 32'(hz_state), 32'd1);
    idle(); tick();

    // Matching registers but ID invalid: no stall
    load_use_rs1(5'd9, 5'd9); id_valid = 1'b0;
    settle_check("idinv_ctl", C_RUN);
    idle();

    // Redirect wins over load-use; load-use masked in FLUSH
    load_use_rs1(5'd5, 5'd5); ex_redirect = 1'b1;
    settle_check("redir_ctl", C_FLUSH);
    tick();
    state_check("redir", 2'd2, 4'd2, 4'd1);
    ex_redirect = 1'b0;
    settle_check("flush_masked_ctl", C_RUN);
    tick();
    check("flush_exit_state", 32'(hz_state), 32'd0);

    // Clear counters
    idle(); cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    state_check("clr", 2'd0, 4'd0, 4'd0);

    // dmem_busy for 3 cycles, redirect ignored on the 2nd
    dmem_busy = 1'b1;
    settle_check("busy1_ctl", C_MEM);
    tick();
    ex_redirect = 1'b1;
    settle_check("busy2_ctl", C_MEM);
    tick();
    ex_redirect = 1'b0;
    settle_check("busy3_ctl", C_MEM);
    tick();
    state_check("busy", 2'd3, 4'd3, 4'd0);
    dmem_busy = 1'b0;
    settle_check("memwait_exit_ctl", C_RUN);
    tick();
    state_check("busy_exit", 2'd0, 4'd3, 4'd0);

    // MEM_WAIT exit straight into a redirect
    dmem_busy = 1'b1; tick();
    dmem_busy = 1'b0; ex_redirect = 1'b1;
    settle_check("memwait_redir_ctl", C_FLUSH);
    tick();
    state_check("memwait_redir", 2'd2, 4'd4, 4'd1);
    idle(); tick();

    // imem not ready for 2 cycles
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    imem_ready = 1'b0;
    settle_check("imem1_ctl", C_IMEM);
    tick();
    settle_check("imem2_ctl", C_IMEM);
    tick();
    state_check("imem", 2'd0, 4'd2, 4'd0);

    // Saturation: 13 more stalls reach 15, one more holds
    for (int i = 0; i < 13; i++) tick();
    check("stall_at_max", 32'(stall_count), 32'd15);
    tick();
    check("stall_sat", 32'(stall_count), 32'd15);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    check("stall_clr_over_inc", 32'(stall_count), 32'd0);
    check("clr_state_kept", 32'(hz_state), 32'd0);
    idle();

    ex_redirect = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    check("flush_sat", 32'(flush_count), 32'd15);
    idle(); tick();

    // Reset while in LOAD_STALL
    load_use_rs1(5'd3, 5'd3); tick();
    check("pre_rst_state", 32'(hz_state), 32'd1);
    rst = 1'b1;
    settle_check("rst_ls_ctl", C_RUN);
    tick();
    state_check("rst_ls", 2'd0, 4'd0, 4'd0);
    rst = 1'b0; idle();
    settle_check("post_rst_ctl", C_RUN);
    tick();
    check("post_rst_state", 32'(hz_state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the performance counters.
REQ-002 Parameter X0_FREE, default 1; when 1, rd = x0 never causes a hazard.
REQ-003 clk_HZD  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_HZD  in  1  synchronous, active-high reset.
REQ-005 ID_rs1, ID_rs2  in  5 each  source registers of the instruction held in IF/ID.
REQ-006 ID_use_rs1, ID_use_rs2  in  1 each  the ID instruction reads the corresponding source.
REQ-007 ID_valid  in  1  valid bit from the IF/ID register.
REQ-008 EX_rd  in  5  destination register of the ID/EX instruction.
REQ-009 EX_MemRead  in  1  the ID/EX instruction is a load.
REQ-010 EX_valid  in  1  valid bit of ID/EX.
REQ-011 EX_redirect  in  1  taken branch/jal/jalr resolved in EX this cycle.
REQ-012 imem_ready  in  1  instruction fetch data valid this cycle.
REQ-013 dmem_busy  in  1  MEM stage access not complete.
REQ-014 cnt_clr  in  1  clears both counters.
REQ-015 en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB  out  1 each  pipeline-register write enables.
REQ-016 NOP_IFID, NOP_IDEX  out  1 each  bubble-insert controls, effective only while the matching enable is 1.
REQ-017 hz_state  out  2  current FSM state.
REQ-018 stall_count, flush_count  out  CNT_W each  performance counters.

Function
REQ-019 FSM states: RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3.
REQ-020 Outputs are combinational from the current state and inputs, so a hazard acts in the cycle it is detected.
REQ-021 Load-use hazard: EX_valid & EX_MemRead & ID_valid & ((ID_use_rs1 & rs1==EX_rd) | (ID_use_rs2 & rs2==EX_rd)), qualified by EX_rd!=0 when X0_FREE=1.
REQ-022 Event priority, highest first: dmem_busy > EX_redirect > load-use > !imem_ready.
REQ-023 dmem_busy, any state: all five enables 0, both NOPs 0; next state MEM_WAIT.
REQ-024 In MEM_WAIT with dmem_busy=0: evaluate the remaining events as in RUN this cycle and take their transition (none -> RUN).
REQ-025 EX_redirect: en_PC=1, en_IFID=1 with NOP_IFID=1, en_IDEX=1 with NOP_IDEX=1, other enables 1; next state FLUSH; flush_count +1.
REQ-026 Load-use: en_PC=0, en_IFID=0, en_IDEX=1 with NOP_IDEX=1, en_EXMEM=1, en_MEMWB=1; next state LOAD_STALL.
REQ-027 In LOAD_STALL and FLUSH, load-use detection is masked for that one cycle; other events are evaluated normally; default next state RUN.
REQ-028 !imem_ready with no higher event: en_PC=0, en_IFID=1 with NOP_IFID=1, all others 1; state unchanged.
REQ-029 No event: all enables 1, NOPs 0; next state RUN.
REQ-030 stall_count increments on every cycle with en_PC=0, saturating at all-ones.
REQ-031 flush_count saturates at all-ones.
REQ-032 cnt_clr zeroes both counters next edge and has priority over increments; state is unaffected.

Reset
REQ-033 When rst_HZD=1 at an edge: state RUN and both counters 0.
REQ-034 While rst_HZD=1: all enables 1 and NOPs 0, so pipeline registers apply their own reset.
REQ-035 Reset mid-stall or mid-flush abandons the state with no residual bubble.

Structure
REQ-036 State encodings and the CNT_W default reside in the shared CPU package.
REQ-037 One sub-module, hazard_cnt (saturating counter with clear), is instantiated twice.
REQ-038 Implementation: one registered state, one combinational decode block.

Verification
REQ-039 Load x5 in EX, ID add uses rs1=x5 -> one cycle en_PC=0, en_IFID=0, NOP_IDEX=1; next cycle RUN, stall_count=1.
REQ-040 Load with EX_rd=0, ID rs1=0, X0_FREE=1 -> no stall, all enables 1.
REQ-041 EX_redirect=1 together with a load-use -> flush wins: NOP_IFID=1, NOP_IDEX=1, en_PC=1, flush_count=1, hz_state=2.
REQ-042 dmem_busy=1 for 3 cycles plus a redirect on cycle 2 -> all enables 0 for 3 cycles, redirect ignored; exit to RUN, stall_count=3.
REQ-043 imem_ready=0 for 2 cycles -> NOP_IFID=1, en_PC=0 each cycle; stall_count=2.
REQ-044 Counter at all-ones plus a further stall -> holds; cnt_clr=1 -> 0 next edge; rst_HZD=1 in LOAD_STALL -> hz_state=0.
